// File: rtl/conv_stage1_divider.sv
// Sequential radix-2 restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per clock.
// Define CONV_DIV_SIGNED_EN for two's-complement operands (truncating division).
`timescale 1ns / 1ps
module conv_stage1_divider (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] dividend_i,
  input  logic [3:0] divisor_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] quot_o,
  output logic [3:0] rem_o,
  output logic       dz_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] r_q, r_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] qsh_q, qsh_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dz_q, dz_d;

  logic [7:0] dvd_mag, q_step, quot_fin;
  logic [3:0] dvs_mag, rem_fin;
  logic [4:0] r_shift, r_step;
  logic       qbit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign r_shift = {r_q[3:0], dvd_q[7]};
  assign qbit    = (r_shift >= {1'b0, dvs_q});
  assign r_step  = qbit ? (r_shift - {1'b0, dvs_q}) : r_shift;
  assign q_step  = {qsh_q[6:0], qbit};

`ifdef CONV_DIV_SIGNED_EN
  logic negq_q, negq_d, negr_q, negr_d;

  // Magnitude of -128 is 8'h80, which the unsigned core handles directly.
  assign dvd_mag  = dividend_i[7] ? (~dividend_i + 8'd1) : dividend_i;
  assign dvs_mag  = divisor_i[3] ? (~divisor_i + 4'd1) : divisor_i;
  assign quot_fin = negq_q ? (~q_step + 8'd1) : q_step;
  assign rem_fin  = negr_q ? (~r_step[3:0] + 4'd1) : r_step[3:0];
`else
  assign dvd_mag  = dividend_i;
  assign dvs_mag  = divisor_i;
  assign quot_fin = q_step;
  assign rem_fin  = r_step[3:0];
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    qsh_d   = qsh_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef CONV_DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (!start_i) begin
          state_d = StIdle;
        end else if (divisor_i == 4'd0) begin
          state_d = StDone;
          quot_d  = 8'hFF;
          rem_d   = 4'h0;
          dz_d    = 1'b1;
        end else begin
          state_d = StRun;
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          r_d     = 5'd0;
          cnt_d   = 3'd0;
          qsh_d   = 8'd0;
`ifdef CONV_DIV_SIGNED_EN
          negq_d  = dividend_i[7] ^ divisor_i[3];
          negr_d  = dividend_i[7];
`endif
        end
      end
      StRun: begin
        dvd_d = {dvd_q[6:0], 1'b0};
        r_d   = r_step;
        qsh_d = q_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StDone;
          quot_d  = quot_fin;
          rem_d   = rem_fin;
          dz_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      r_q     <= 5'd0;
      cnt_q   <= 3'd0;
      qsh_q   <= 8'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      dz_q    <= 1'b0;
`ifdef CONV_DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      qsh_q   <= qsh_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef CONV_DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_conv_stage1_divider.sv
// Self-checking bench for conv_stage1_divider: directed plan cases plus random operations
// compared against an arithmetic reference model.
`timescale 1ns / 1ps
module tb_conv_stage1_divider;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic       busy_o, done_o, dz_o;
  logic [7:0] quot_o;
  logic [3:0] rem_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  conv_stage1_divider u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .dz_o       (dz_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation in the signed build.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r, output logic z);
    int sa, sb, iq, ir;
    if (b == 4'd0) begin
      q = 8'hFF; r = 4'h0; z = 1'b1;
    end else begin
`ifdef CONV_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[7:0];
      r  = ir[3:0];
      z  = 1'b0;
    end
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input bit inject);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         j, nbusy;
    model(a, b, eq, er, ez);
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; dividend_i = 8'($urandom); divisor_i = 4'($urandom);
    j = 0; nbusy = 0;
    while (!done_o && j < 20) begin
      if (busy_o) nbusy++;
      if (inject && j == 3) begin start_i = 1'b1; dividend_i = 8'h55; divisor_i = 4'h3; end
      if (inject && j == 4) start_i = 1'b0;
      @(posedge clk_i); #1;
      j++;
    end
    chk("latency", 32'(j), ez ? 32'd0 : 32'd8);
    chk("busy_cycles", 32'(nbusy), ez ? 32'd0 : 32'd8);
    chk("done", 32'(done_o), 32'd1);
    chk("busy_at_done", 32'(busy_o), 32'd0);
    chk("quot", 32'(quot_o), 32'(eq));
    chk("rem", 32'(rem_o), 32'(er));
    chk("dz", 32'(dz_o), 32'(ez));
    @(posedge clk_i); #1;
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("hold_quot", 32'(quot_o), 32'(eq));
  endtask

  initial begin
    logic [7:0] bq;
    logic [3:0] br;
    logic       bz;
    int         npulse;
    int         pos[4];

    rst_ni = 1'b0; start_i = 1'b0; dividend_i = 8'd0; divisor_i = 4'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_quot", 32'(quot_o), 32'd0);
    chk("rst_rem", 32'(rem_o), 32'd0);
    chk("rst_dz", 32'(dz_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_op(8'd200, 4'd7, 1'b0);
`ifndef CONV_DIV_SIGNED_EN
    chk("basic_quot_const", 32'(quot_o), 32'h1C);
    chk("basic_rem_const", 32'(rem_o), 32'h4);
`endif
    do_op(8'd255, 4'd15, 1'b0);
    do_op(8'd0, 4'd9, 1'b0);
    do_op(8'd14, 4'd15, 1'b0);
    do_op(8'd37, 4'd0, 1'b0);
    do_op(8'd37, 4'd5, 1'b0);
`ifndef CONV_DIV_SIGNED_EN
    chk("after_dz_quot_const", 32'(quot_o), 32'd7);
    chk("after_dz_rem_const", 32'(rem_o), 32'd2);
`endif
    do_op(8'd200, 4'd7, 1'b1);

    // Held start: three back-to-back operations, done every 9 cycles.
    model(8'd100, 4'd3, bq, br, bz);
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 8'd100; divisor_i = 4'd3;
    @(posedge clk_i); #1;
    npulse = 0;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        if (npulse < 4) pos[npulse] = c;
        npulse++;
        chk("b2b_quot", 32'(quot_o), 32'(bq));
      end
    end
    start_i = 1'b0;
    chk("b2b_pulses", 32'(npulse), 32'd3);
    chk("b2b_pos0", 32'(pos[0]), 32'd8);
    chk("b2b_pos1", 32'(pos[1]), 32'd17);
    chk("b2b_pos2", 32'(pos[2]), 32'd26);
    repeat (2) @(posedge clk_i);

    // Asynchronous reset partway through RUN.
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 8'd200; divisor_i = 4'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_quot", 32'(quot_o), 32'd0);
    chk("arst_rem", 32'(rem_o), 32'd0);
    chk("arst_dz", 32'(dz_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_op(8'd100, 4'd3, 1'b0);
`ifndef CONV_DIV_SIGNED_EN
    chk("post_rst_quot_const", 32'(quot_o), 32'd33);
    chk("post_rst_rem_const", 32'(rem_o), 32'd1);
`endif

`ifdef CONV_DIV_SIGNED_EN
    do_op(8'h9C, 4'd7, 1'b0);
    chk("s_neg_dvd_quot", 32'(quot_o), 32'hF2);
    chk("s_neg_dvd_rem", 32'(rem_o), 32'hE);
    do_op(8'd100, 4'h9, 1'b0);
    chk("s_neg_dvs_quot", 32'(quot_o), 32'hF2);
    chk("s_neg_dvs_rem", 32'(rem_o), 32'h2);
    do_op(8'h80, 4'hF, 1'b0);
    chk("s_wrap_quot", 32'(quot_o), 32'h80);
`endif

    repeat (40) do_op(8'($urandom), 4'($urandom_range(0, 15)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
